// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared state encoding and control-bit indices for the
// memory-access stage.
package mem_stage_pkg;

  // Legacy-compatible raw encodings, reused by the enum below
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  typedef enum logic [0:0] {IDLE = S_IDLE, BUSY = S_BUSY} state_t;

  // M control bit positions
  localparam int M_JUMP     = 3;
  localparam int M_BRANCH   = 2;
  localparam int M_MEMREAD  = 1;
  localparam int M_MEMWRITE = 0;

  // WB control bit positions
  localparam int WB_REGWRITE = 0;
  localparam int WB_MEMTOREG = 1;
  localparam int WB_LINK     = 2;

  // Word accesses only: low two address bits must be clear
  function automatic logic is_aligned(input logic [1:0] a);
    return a == 2'b00;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: req/ack data-memory port. master = pipeline stage,
// slave = memory.
interface mem_stage_if #(parameter int DATA_W = 32);
  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;

  modport master (output dmem_req, dmem_we, dmem_addr, dmem_wdata,
                  input  dmem_ack, dmem_rdata);
  modport slave  (input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
                  output dmem_ack, dmem_rdata);
endinterface

// File: rtl/mem_stage_dmem_if.sv
// dmem_if: IDLE/BUSY access FSM, request registers and ack handling.
// Optional feature macro: MEM_TIMEOUT_EN (aborts an access after TIMEOUT
// BUSY cycles without ack).
module dmem_if
  import mem_stage_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_we,
  input  logic [DATA_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  mem_stage_if.master       bus,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_timeout,
  output logic              o_we
);

  state_t            r_state;
  logic              r_we;
  logic [DATA_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  assign o_busy = (r_state == BUSY);
  // Ack only counts while an access is outstanding; stray acks in IDLE drop
  assign o_done = o_busy & bus.dmem_ack;
  assign o_we   = r_we;

  assign bus.dmem_req   = o_busy;
  assign bus.dmem_we    = r_we;
  assign bus.dmem_addr  = r_addr;
  assign bus.dmem_wdata = r_wdata;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) < 8) ? 8 : $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] r_cnt;

  // Fires in the TIMEOUT-th BUSY cycle so req is high exactly TIMEOUT cycles
  assign o_timeout = o_busy & ~bus.dmem_ack & (r_cnt == CNT_W'(TIMEOUT - 1));

  // Count BUSY cycles of the current access
  always_ff @(posedge clk) begin
    if (rst || !o_busy) r_cnt <= '0;
    else                r_cnt <= r_cnt + 1'b1;
  end
`else
  assign o_timeout = 1'b0;
`endif

  // Access FSM; request fields are frozen for the whole BUSY period
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: if (i_start) begin
          r_state <= BUSY;
          r_we    <= i_we;
          r_addr  <= i_addr;
          r_wdata <= i_wdata;
        end
        BUSY: if (o_done || o_timeout) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the 5-stage pipeline. Branch/jump resolution,
// load/store shadow registers and the MEM/WB pipeline register.
// Optional feature macro: MEM_TIMEOUT_EN (handled inside dmem_if).
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        WB_in,
  input  logic [3:0]        M_in,
  input  logic [DATA_W-1:0] alu_in,
  input  logic [DATA_W-1:0] wd_in,
  input  logic [4:0]        rd_rt_in,
  input  logic [DATA_W-1:0] branch_pc_in,
  input  logic [DATA_W-1:0] jump_addr_in,
  input  logic [DATA_W-1:0] pc_in,
  output logic              stall,
  mem_stage_if.master       dmem,
  output logic              redirect,
  output logic [DATA_W-1:0] redirect_pc,
  output logic              mem_err,
  output logic [2:0]        WB_out,
  output logic [DATA_W-1:0] rdata_out,
  output logic [DATA_W-1:0] alu_out,
  output logic [DATA_W-1:0] pc_out,
  output logic [4:0]        rd_rt_out
);

  logic              w_memop, w_aligned, w_start, w_busy, w_done, w_timeout;
  logic              w_we, w_taken;
  logic [DATA_W-1:0] w_target;

  logic [2:0]        r_sh_wb;
  logic [4:0]        r_sh_rd;
  logic [DATA_W-1:0] r_sh_alu, r_sh_pc;

  assign w_memop   = M_in[M_MEMREAD] | M_in[M_MEMWRITE];
  assign w_aligned = is_aligned(alu_in[1:0]);
  assign w_start   = ~rst & ~w_busy & w_memop & w_aligned;
  assign w_taken   = M_in[M_JUMP] | (M_in[M_BRANCH] & (alu_in == '0));
  assign w_target  = M_in[M_JUMP] ? jump_addr_in : branch_pc_in;

  // Stall drops in the ack/timeout cycle so EX/MEM advances on that edge
  assign stall = ~rst & (w_start | (w_busy & ~w_done & ~w_timeout));

  dmem_if #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) u_dmem_if (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_start),
    .i_we      (M_in[M_MEMWRITE]),   // read+write together acts as a write
    .i_addr    (alu_in),
    .i_wdata   (wd_in),
    .bus       (dmem),
    .o_busy    (w_busy),
    .o_done    (w_done),
    .o_timeout (w_timeout),
    .o_we      (w_we)
  );

  // Capture the instruction's writeback fields when its access starts
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh_wb  <= '0;
      r_sh_rd  <= '0;
      r_sh_alu <= '0;
      r_sh_pc  <= '0;
    end else if (w_start) begin
      r_sh_wb  <= WB_in;
      r_sh_rd  <= rd_rt_in;
      r_sh_alu <= alu_in;
      r_sh_pc  <= pc_in;
    end
  end

  // MEM/WB register plus one-cycle redirect and error pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      WB_out      <= '0;
      rdata_out   <= '0;
      alu_out     <= '0;
      pc_out      <= '0;
      rd_rt_out   <= '0;
      redirect    <= 1'b0;
      redirect_pc <= '0;
      mem_err     <= 1'b0;
    end else begin
      redirect <= 1'b0;
      mem_err  <= 1'b0;
      if (w_busy) begin
        if (w_done) begin
          WB_out    <= r_sh_wb;
          rd_rt_out <= r_sh_rd;
          alu_out   <= r_sh_alu;
          pc_out    <= r_sh_pc;
          rdata_out <= w_we ? '0 : dmem.dmem_rdata;
        end else begin
          // Bubble every waiting cycle so WB never commits twice
          WB_out  <= '0;
          mem_err <= w_timeout;
        end
      end else if (w_memop) begin
        // Start (bubble) or misaligned (suppressed) access
        WB_out    <= '0;
        rdata_out <= '0;
        rd_rt_out <= rd_rt_in;
        alu_out   <= alu_in;
        pc_out    <= pc_in;
        mem_err   <= ~w_aligned;
      end else begin
        WB_out      <= WB_in;
        rdata_out   <= '0;
        rd_rt_out   <= rd_rt_in;
        alu_out     <= alu_in;
        pc_out      <= pc_in;
        redirect    <= w_taken;
        redirect_pc <= w_target;
      end
    end
  end

endmodule
